// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: program counter, next-PC redirect/exception entry,
// fetch address-error detection and the F/D pipeline register feeding decode.
module fetch_pc_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        exc_req,
    input  logic        npc_sel,
    input  logic [31:0] npc_target,
    input  logic        npc_is_slot,
    input  logic        npc_clear_slot,
    input  logic [31:0] i_instr,
    output logic [31:0] i_addr,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_bd,
    output logic [4:0]  d_exc_code,
    output logic        d_valid
);

    localparam logic [31:0] ResetPc   = 32'h0000_3000;
    localparam logic [31:0] HandlerPc = 32'h0000_4180;
    localparam logic [31:0] FetchLo   = 32'h0000_3000;
    localparam logic [31:0] FetchHi   = 32'h0000_6FFC;
    localparam logic [4:0]  ExcNone   = 5'd0;
    localparam logic [4:0]  ExcAdEL   = 5'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_bd_q, d_bd_d;
    logic [4:0]  d_exc_code_q, d_exc_code_d;
    logic        d_valid_q, d_valid_d;

    logic        f_adel;
    logic [31:0] pc_plus4;

    assign f_adel   = (pc_q[1:0] != 2'b00) | (pc_q < FetchLo) | (pc_q > FetchHi);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d         = pc_q;
        d_pc_d       = d_pc_q;
        d_instr_d    = d_instr_q;
        d_bd_d       = d_bd_q;
        d_exc_code_d = d_exc_code_q;
        d_valid_d    = d_valid_q;

        if (exc_req) begin
            // Exception entry wins over a stall so the handler is never delayed.
            pc_d         = HandlerPc;
            d_pc_d       = 32'd0;
            d_instr_d    = 32'd0;
            d_bd_d       = 1'b0;
            d_exc_code_d = ExcNone;
            d_valid_d    = 1'b0;
        end else if (stall_f) begin
            // Hold everything; decode re-presents its redirect after the stall.
        end else if (npc_clear_slot) begin
            pc_d         = npc_target;
            d_pc_d       = pc_q;
            d_instr_d    = 32'd0;
            d_bd_d       = 1'b0;
            d_exc_code_d = ExcNone;
            d_valid_d    = 1'b0;
        end else begin
            pc_d      = npc_sel ? npc_target : pc_plus4;
            d_pc_d    = pc_q;
            d_bd_d    = npc_is_slot;
            d_valid_d = 1'b1;
            if (f_adel) begin
                d_instr_d    = 32'd0;
                d_exc_code_d = ExcAdEL;
            end else begin
                d_instr_d    = i_instr;
                d_exc_code_d = ExcNone;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= ResetPc;
            d_pc_q       <= 32'd0;
            d_instr_q    <= 32'd0;
            d_bd_q       <= 1'b0;
            d_exc_code_q <= ExcNone;
            d_valid_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            d_pc_q       <= d_pc_d;
            d_instr_q    <= d_instr_d;
            d_bd_q       <= d_bd_d;
            d_exc_code_q <= d_exc_code_d;
            d_valid_q    <= d_valid_d;
        end
    end

    assign i_addr     = pc_q;
    assign d_pc       = d_pc_q;
    assign d_instr    = d_instr_q;
    assign d_bd       = d_bd_q;
    assign d_exc_code = d_exc_code_q;
    assign d_valid    = d_valid_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: expected post-edge state is pushed when
// stimulus is driven and popped/compared one time unit after the rising edge.
module tb_fetch_pc_stage;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        exc_req;
    logic        npc_sel;
    logic [31:0] npc_target;
    logic        npc_is_slot;
    logic        npc_clear_slot;
    logic [31:0] i_instr;
    logic [31:0] i_addr;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_bd;
    logic [4:0]  d_exc_code;
    logic        d_valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] d_pc;
        logic [31:0] d_instr;
        logic        d_bd;
        logic [4:0]  d_exc;
        logic        d_valid;
    } st_t;

    st_t m;
    st_t sb_q[$];
    int  tests_run;
    int  tests_failed;

    fetch_pc_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall_f        (stall_f),
        .exc_req        (exc_req),
        .npc_sel        (npc_sel),
        .npc_target     (npc_target),
        .npc_is_slot    (npc_is_slot),
        .npc_clear_slot (npc_clear_slot),
        .i_instr        (i_instr),
        .i_addr         (i_addr),
        .d_pc           (d_pc),
        .d_instr        (d_instr),
        .d_bd           (d_bd),
        .d_exc_code     (d_exc_code),
        .d_valid        (d_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    assign i_instr = imem(i_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic st_t model_next(input st_t cur, input logic rst, input logic stl,
                                       input logic exc, input logic sel, input logic [31:0] tgt,
                                       input logic slot, input logic clr);
        st_t n;
        logic bad;
        n = cur;
        bad = (cur.pc[1:0] != 2'b00) || (cur.pc < 32'h3000) || (cur.pc > 32'h6FFC);
        if (rst) begin
            n = '0;
            n.pc = 32'h3000;
        end else if (exc) begin
            n = '0;
            n.pc = 32'h4180;
        end else if (stl) begin
            n = cur;
        end else if (clr) begin
            n = '0;
            n.pc = tgt;
            n.d_pc = cur.pc;
        end else begin
            n.pc      = sel ? tgt : cur.pc + 32'd4;
            n.d_pc    = cur.pc;
            n.d_bd    = slot;
            n.d_valid = 1'b1;
            n.d_instr = bad ? 32'd0 : imem(cur.pc);
            n.d_exc   = bad ? 5'd4 : 5'd0;
        end
        return n;
    endfunction

    task automatic step(input logic rst, input logic stl, input logic exc, input logic sel,
                        input logic [31:0] tgt, input logic slot, input logic clr);
        st_t e;
        @(negedge clk);
        reset = rst; stall_f = stl; exc_req = exc; npc_sel = sel;
        npc_target = tgt; npc_is_slot = slot; npc_clear_slot = clr;
        if (!rst) check_val("i_addr_pre", i_addr, m.pc);
        sb_q.push_back(model_next(m, rst, stl, exc, sel, tgt, slot, clr));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            check_val("i_addr",  i_addr, e.pc);
            check_val("d_pc",    d_pc, e.d_pc);
            check_val("d_instr", d_instr, e.d_instr);
            check_val("d_bd",    {31'd0, d_bd}, {31'd0, e.d_bd});
            check_val("d_exc",   {27'd0, d_exc_code}, {27'd0, e.d_exc});
            check_val("d_valid", {31'd0, d_valid}, {31'd0, e.d_valid});
            m = e;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0; tests_failed = 0; m = '0;
        reset = 1'b1; stall_f = 1'b0; exc_req = 1'b0; npc_sel = 1'b0;
        npc_target = 32'd0; npc_is_slot = 1'b0; npc_clear_slot = 1'b0;

        // Reset with absolute spot checks, then free run.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("rst_pc", i_addr, 32'h3000);
        check_val("rst_valid", {31'd0, d_valid}, 32'd0);
        run(3);
        check_val("free_pc", i_addr, 32'h300C);
        check_val("free_dpc", d_pc, 32'h3008);

        // Taken beq at 0x3008.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        run(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3100, 1'b1, 1'b0);
        check_val("beq_pc", i_addr, 32'h3100);
        check_val("beq_bd", {31'd0, d_bd}, 32'd1);
        run(1);
        check_val("beq_bd_after", {31'd0, d_bd}, 32'd0);

        // Exception entry, then eret from 0x4184.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        run(1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 1'b1);
        check_val("eret_pc", i_addr, 32'h3200);
        check_val("eret_dpc", d_pc, 32'h4184);

        // Misaligned and out-of-range jr targets.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3001, 1'b1, 1'b0);
        run(1);
        check_val("jr_mis_exc", {27'd0, d_exc_code}, 32'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h7000, 1'b1, 1'b0);
        run(1);
        check_val("jr_hi_exc", {27'd0, d_exc_code}, 32'd4);

        // Upper legal boundary 0x6FFC.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h6FFC, 1'b0, 1'b0);
        run(2);

        // Wrap of pc + 4.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        run(2);
        check_val("wrap_dpc", d_pc, 32'h0);

        // Stall at 0x3010 with redirect pulsed.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        run(4);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3400, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3400, 1'b1, 1'b0);
        check_val("stall_pc", i_addr, 32'h3010);
        run(1);
        check_val("unstall_pc", i_addr, 32'h3014);

        // Stall plus exception at 0x3020, then reset with exception.
        run(3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("stall_exc_pc", i_addr, 32'h4180);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0);
        check_val("rst_exc_pc", i_addr, 32'h3000);
        run(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
